bram_dp_2048x9: RTL and testbench
=================================

Name: bram_dp_2048x9

Overview:
- True dual-port synchronous block RAM: 2048 words x 9 bits (8 data + 1 parity), exposed through two independent read/write ports A and B.
- Both ports run on a single clock.
- Used as the technology-mapped storage primitive beneath generic 2048x8 memory wrappers; wrappers tie parity inputs to 0 and ignore parity outputs.

Parameters:
- INIT_A, 9'h000, power-up/async-reset value of port A output latch {DOPA,DOA}
- INIT_B, 9'h000, power-up/async-reset value of port B output latch {DOPB,DOB}
- SRVAL_A, 9'h000, value loaded into port A output latch by SSRA
- SRVAL_B, 9'h000, value loaded into port B output latch by SSRB
- WRITE_MODE_A, "WRITE_FIRST", port A output on write: "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE"
- WRITE_MODE_B, "WRITE_FIRST", same for port B

Ports:
- CLK in 1: single clock; all synchronous activity on rising edge
- RST in 1: asynchronous active-high reset
- ADDRA in 11: port A word address
- DIA in 8: port A write data
- DIPA in 1: port A write parity
- ENA in 1: port A enable
- WEA in 1: port A write enable (qualified by ENA)
- SSRA in 1: port A synchronous output set/reset
- DOA out 8: port A read data
- DOPA out 1: port A read parity
- ADDRB, DIB, DIPB, ENB, WEB, SSRB, DOB, DOPB: identical set for port B

Behaviour:
- Storage: 2048 x 9 array, bit 8 = parity. Contents are not initialised and not cleared by RST.
- RST high (asynchronous): {DOPA,DOA} = INIT_A, {DOPB,DOB} = INIT_B immediately; no array writes occur while RST is high. Deassertion is synchronised by the next rising CLK edge.
- Read latency is 1 cycle. Outputs are registered and hold their value whenever the port is disabled (EN=0).
- Per port, on a rising CLK edge with EN=1, in priority order:
  1. SSR=1: output latch loads SRVAL; a write still occurs if WE=1.
  2. WE=1: mem[ADDR] <= {DIP,DI}. Output depends on WRITE_MODE:
     - WRITE_FIRST: output = new data
     - READ_FIRST: output = old mem[ADDR]
     - NO_CHANGE: output holds
  3. WE=0: output = mem[ADDR].
- Cross-port, same address, same edge:
  - Both write: port B data is stored.
  - One reads while the other writes: the reader gets the pre-write (old) contents.
  - Both read: both ports return the same word.
- EN=0: WE and SSR are ignored; no write, output held.
- Address range covers all 0..2047; no wrap or out-of-range case.

Optional Feature:
- Macro BRAM_OUTPUT_REG_EN.
- When defined: an extra output pipeline register per port, enabled by that port's EN and reset asynchronously by RST to INIT_x. Read latency is 2 cycles. SSR acts on the final output register.
- When undefined: latency is 1 as above.
- Ports are identical in both builds.

Test Plan:
- Reset: assert RST mid-cycle with outputs showing data -> DOA/DOPA = INIT_A and DOB/DOPB = INIT_B immediately. After release with ENA=ENB=0, outputs stay at INIT values.
- Write/read A: ENA=1, WEA=1, ADDRA=11'h123, DIA=8'hA5, DIPA=1. Then WEA=0 same address -> DOA=8'hA5, DOPA=1 one cycle after the read edge (two with BRAM_OUTPUT_REG_EN).
- Cross-port: write 8'h3C to address 11'h7FF via A, then read 11'h7FF via B -> DOB=8'h3C. Address 11'h000 is unaffected.
- Write modes: mem[5]=8'h11, then write 8'h22 to address 5 ->
  - WRITE_FIRST: DO=8'h22
  - READ_FIRST: DO=8'h11
  - NO_CHANGE: prior output retained
- Collision: same edge, A writes 8'hAA and B writes 8'h55 to address 11'h010 -> later read returns 8'h55. Separately, A write 8'h77 with B read of the same address on the same edge -> DOB shows the old value.
- SSR/enable: SSRA=1 with ENA=1 and SRVAL_A=9'h1FF -> DOA=8'hFF, DOPA=1. SSRA=1 with ENA=0 -> output unchanged.

Source files
------------

// File: rtl/bram_dp_2048x9.sv
// rtl/bram_dp_2048x9.sv - true dual-port 2048x9 block RAM, single clock, registered outputs.
// Optional BRAM_OUTPUT_REG_EN adds a second output register per port (read latency 2).
module bram_dp_2048x9 #(
  parameter logic [8:0] INIT_A       = 9'h000,
  parameter logic [8:0] INIT_B       = 9'h000,
  parameter logic [8:0] SRVAL_A      = 9'h000,
  parameter logic [8:0] SRVAL_B      = 9'h000,
  parameter string      WRITE_MODE_A = "WRITE_FIRST",
  parameter string      WRITE_MODE_B = "WRITE_FIRST"
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [10:0] ADDRA,
  input  logic [7:0]  DIA,
  input  logic        DIPA,
  input  logic        ENA,
  input  logic        WEA,
  input  logic        SSRA,
  output logic [7:0]  DOA,
  output logic        DOPA,
  input  logic [10:0] ADDRB,
  input  logic [7:0]  DIB,
  input  logic        DIPB,
  input  logic        ENB,
  input  logic        WEB,
  input  logic        SSRB,
  output logic [7:0]  DOB,
  output logic        DOPB
);

  localparam logic [1:0] MODE_WF = 2'd0;
  localparam logic [1:0] MODE_RF = 2'd1;
  localparam logic [1:0] MODE_NC = 2'd2;

  localparam logic [1:0] MODE_A = (WRITE_MODE_A == "READ_FIRST") ? MODE_RF :
                                  (WRITE_MODE_A == "NO_CHANGE")  ? MODE_NC : MODE_WF;
  localparam logic [1:0] MODE_B = (WRITE_MODE_B == "READ_FIRST") ? MODE_RF :
                                  (WRITE_MODE_B == "NO_CHANGE")  ? MODE_NC : MODE_WF;

  logic [8:0] mem [0:2047];

  logic [8:0] din_a, din_b;
  logic [8:0] rd_a, rd_b;
  logic [8:0] lat_a_d, lat_a_q;
  logic [8:0] lat_b_d, lat_b_q;

  assign din_a = {DIPA, DIA};
  assign din_b = {DIPB, DIB};

  // Reads sample the array before this edge's writes, so a cross-port reader sees old data.
  assign rd_a = mem[ADDRA];
  assign rd_b = mem[ADDRB];

  // Port B is written last so it wins a same-address collision.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (ENA && WEA) mem[ADDRA] <= din_a;
      if (ENB && WEB) mem[ADDRB] <= din_b;
    end
  end

  always_comb begin
    lat_a_d = lat_a_q;
    if (ENA) begin
      if (!WEA)                  lat_a_d = rd_a;
      else if (MODE_A == MODE_WF) lat_a_d = din_a;
      else if (MODE_A == MODE_RF) lat_a_d = rd_a;
`ifndef BRAM_OUTPUT_REG_EN
      if (SSRA) lat_a_d = SRVAL_A;
`endif
    end
  end

  always_comb begin
    lat_b_d = lat_b_q;
    if (ENB) begin
      if (!WEB)                  lat_b_d = rd_b;
      else if (MODE_B == MODE_WF) lat_b_d = din_b;
      else if (MODE_B == MODE_RF) lat_b_d = rd_b;
`ifndef BRAM_OUTPUT_REG_EN
      if (SSRB) lat_b_d = SRVAL_B;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lat_a_q <= INIT_A;
      lat_b_q <= INIT_B;
    end else begin
      lat_a_q <= lat_a_d;
      lat_b_q <= lat_b_d;
    end
  end

`ifdef BRAM_OUTPUT_REG_EN
  logic [8:0] out_a_d, out_a_q;
  logic [8:0] out_b_d, out_b_q;

  // Set/reset applies to the final register so it takes effect after one edge.
  always_comb begin
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    if (ENA) out_a_d = SSRA ? SRVAL_A : lat_a_q;
    if (ENB) out_b_d = SSRB ? SRVAL_B : lat_b_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_a_q <= INIT_A;
      out_b_q <= INIT_B;
    end else begin
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

  assign {DOPA, DOA} = out_a_q;
  assign {DOPB, DOB} = out_b_q;
`else
  assign {DOPA, DOA} = lat_a_q;
  assign {DOPB, DOB} = lat_b_q;
`endif

endmodule

// File: tb/tb_bram_dp_2048x9.sv
// tb/tb_bram_dp_2048x9.sv - randomized and directed self-checking bench for bram_dp_2048x9.
module tb_bram_dp_2048x9;

`ifdef BRAM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [10:0] addra = '0, addrb = '0;
  logic [7:0]  dia = '0, dib = '0;
  logic        dipa = 1'b0, dipb = 1'b0;
  logic        ena = 1'b0, enb = 1'b0, wea = 1'b0, web = 1'b0, ssra = 1'b0, ssrb = 1'b0;

  logic [7:0] doa0, dob0, doa1, dob1;
  logic       dopa0, dopb0, dopa1, dopb1;

  bram_dp_2048x9 #(
    .INIT_A(9'h0AB), .INIT_B(9'h1CD), .SRVAL_A(9'h1FF), .SRVAL_B(9'h0F0),
    .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST")
  ) dut0 (
    .CLK(clk), .RST(rst),
    .ADDRA(addra), .DIA(dia), .DIPA(dipa), .ENA(ena), .WEA(wea), .SSRA(ssra),
    .DOA(doa0), .DOPA(dopa0),
    .ADDRB(addrb), .DIB(dib), .DIPB(dipb), .ENB(enb), .WEB(web), .SSRB(ssrb),
    .DOB(dob0), .DOPB(dopb0)
  );

  bram_dp_2048x9 #(
    .INIT_A(9'h155), .INIT_B(9'h0AA), .SRVAL_A(9'h123), .SRVAL_B(9'h001),
    .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("NO_CHANGE")
  ) dut1 (
    .CLK(clk), .RST(rst),
    .ADDRA(addra), .DIA(dia), .DIPA(dipa), .ENA(ena), .WEA(wea), .SSRA(ssra),
    .DOA(doa1), .DOPA(dopa1),
    .ADDRB(addrb), .DIB(dib), .DIPB(dipb), .ENB(enb), .WEB(web), .SSRB(ssrb),
    .DOB(dob1), .DOPB(dopb1)
  );

  // Port index: 0 = dut0 A (write-first), 1 = dut0 B (read-first), 2/3 = dut1 A/B (no-change)
  logic [8:0] obs [4];
  always_comb begin
    obs[0] = {dopa0, doa0};
    obs[1] = {dopb0, dob0};
    obs[2] = {dopa1, doa1};
    obs[3] = {dopb1, dob1};
  end

  int checks = 0;
  int fails  = 0;

  logic [8:0] mmem [2048];
  logic [8:0] lat  [4];
  logic [8:0] outr [4];
  int         mode [4] = '{0, 1, 2, 2};
  logic [8:0] srv  [4] = '{9'h1FF, 9'h0F0, 9'h123, 9'h001};
  logic [8:0] ini  [4] = '{9'h0AB, 9'h1CD, 9'h155, 9'h0AA};

  function automatic logic [8:0] exp_o(int p);
`ifdef BRAM_OUTPUT_REG_EN
    return outr[p];
`else
    return lat[p];
`endif
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      lat[p]  = ini[p];
      outr[p] = ini[p];
    end
  endtask

  // One rising edge of behaviour: all reads see the array before any write of this edge.
  task automatic model_step();
    logic [8:0] rd, din;
    logic en, we, ss;
    if (rst) begin
      model_reset();
      return;
    end
    for (int p = 0; p < 4; p++) begin
      en  = (p % 2 == 0) ? ena : enb;
      we  = (p % 2 == 0) ? wea : web;
      ss  = (p % 2 == 0) ? ssra : ssrb;
      rd  = (p % 2 == 0) ? mmem[addra] : mmem[addrb];
      din = (p % 2 == 0) ? {dipa, dia} : {dipb, dib};
      if (en) begin
`ifdef BRAM_OUTPUT_REG_EN
        outr[p] = ss ? srv[p] : lat[p];
`endif
        if (!we) lat[p] = rd;
        else if (mode[p] == 0) lat[p] = din;
        else if (mode[p] == 1) lat[p] = rd;
`ifndef BRAM_OUTPUT_REG_EN
        if (ss) lat[p] = srv[p];
`endif
      end
    end
    if (ena && wea) mmem[addra] = {dipa, dia};
    if (enb && web) mmem[addrb] = {dipb, dib};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_a(logic en, logic we, logic ss, logic [10:0] ad, logic [8:0] d);
    ena = en; wea = we; ssra = ss; addra = ad; {dipa, dia} = d;
  endtask

  task automatic drive_b(logic en, logic we, logic ss, logic [10:0] ad, logic [8:0] d);
    enb = en; web = we; ssrb = ss; addrb = ad; {dipb, dib} = d;
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst = 1'b1;
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (obs[p] !== ini[p]) begin
        fails++;
        $display("FAIL reset_init port%0d: got %h expected %h", p, obs[p], ini[p]);
      end
    end
    @(negedge clk);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (obs[p] !== exp_o(p)) begin
        fails++;
        $display("FAIL reset_hold port%0d: got %h expected %h", p, obs[p], exp_o(p));
      end
    end
  endtask

  task automatic test_write_read_a();
    drive_a(1, 1, 0, 11'h123, 9'h1A5);
    tick();
    drive_a(1, 0, 0, 11'h123, 9'h000);
    repeat (LAT) tick();
    checks++;
    if (obs[0] !== 9'h1A5) begin
      fails++;
      $display("FAIL write_read_a: got %h expected %h", obs[0], 9'h1A5);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (obs[p] !== exp_o(p)) begin
        fails++;
        $display("FAIL write_read_a_model port%0d: got %h expected %h", p, obs[p], exp_o(p));
      end
    end
  endtask

  task automatic test_cross_port();
    drive_a(1, 1, 0, 11'h000, 9'h0E1);
    tick();
    drive_a(1, 1, 0, 11'h7FF, 9'h03C);
    tick();
    drive_a(0, 0, 0, 11'h000, 9'h000);
    drive_b(1, 0, 0, 11'h7FF, 9'h000);
    repeat (LAT) tick();
    checks++;
    if (obs[1] !== 9'h03C) begin
      fails++;
      $display("FAIL cross_read_7ff: got %h expected %h", obs[1], 9'h03C);
    end
    drive_b(1, 0, 0, 11'h000, 9'h000);
    repeat (LAT) tick();
    checks++;
    if (obs[1] !== 9'h0E1) begin
      fails++;
      $display("FAIL cross_addr0_intact: got %h expected %h", obs[1], 9'h0E1);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (obs[p] !== exp_o(p)) begin
        fails++;
        $display("FAIL cross_model port%0d: got %h expected %h", p, obs[p], exp_o(p));
      end
    end
    drive_b(0, 0, 0, 11'h000, 9'h000);
  endtask

  task automatic test_write_modes();
    drive_a(1, 1, 0, 11'd5, 9'h011);
    tick();
    drive_a(1, 0, 0, 11'd5, 9'h000);
    repeat (LAT) tick();
    drive_a(0, 0, 0, 11'd0, 9'h000);
    drive_b(1, 0, 0, 11'd0, 9'h000);
    repeat (LAT) tick();
    drive_b(1, 1, 0, 11'd5, 9'h022);
    repeat (LAT) tick();
    checks++;
    if (obs[1] !== 9'h011) begin
      fails++;
      $display("FAIL mode_read_first: got %h expected %h", obs[1], 9'h011);
    end
    checks++;
    if (obs[3] !== 9'h0E1) begin
      fails++;
      $display("FAIL mode_no_change_b: got %h expected %h", obs[3], 9'h0E1);
    end
    drive_b(0, 0, 0, 11'd0, 9'h000);
    drive_a(1, 1, 0, 11'd5, 9'h033);
    repeat (LAT) tick();
    checks++;
    if (obs[0] !== 9'h033) begin
      fails++;
      $display("FAIL mode_write_first: got %h expected %h", obs[0], 9'h033);
    end
    checks++;
    if (obs[2] !== 9'h011) begin
      fails++;
      $display("FAIL mode_no_change_a: got %h expected %h", obs[2], 9'h011);
    end
    drive_a(0, 0, 0, 11'd0, 9'h000);
  endtask

  task automatic test_collision();
    drive_a(1, 1, 0, 11'h010, 9'h0AA);
    drive_b(1, 1, 0, 11'h010, 9'h055);
    tick();
    drive_b(0, 0, 0, 11'h000, 9'h000);
    drive_a(1, 0, 0, 11'h010, 9'h000);
    repeat (LAT) tick();
    checks++;
    if (obs[0] !== 9'h055) begin
      fails++;
      $display("FAIL collision_b_wins: got %h expected %h", obs[0], 9'h055);
    end
    drive_a(1, 1, 0, 11'h020, 9'h0C3);
    tick();
    drive_a(1, 1, 0, 11'h020, 9'h077);
    drive_b(1, 0, 0, 11'h020, 9'h000);
    repeat (LAT) tick();
    checks++;
    if (obs[1] !== 9'h0C3) begin
      fails++;
      $display("FAIL collision_read_old: got %h expected %h", obs[1], 9'h0C3);
    end
    checks++;
    if (obs[3] !== 9'h0C3) begin
      fails++;
      $display("FAIL collision_read_old_nc: got %h expected %h", obs[3], 9'h0C3);
    end
    drive_a(0, 0, 0, 11'h000, 9'h000);
    drive_b(0, 0, 0, 11'h000, 9'h000);
  endtask

  task automatic test_ssr_enable();
    drive_a(1, 0, 0, 11'h123, 9'h000);
    repeat (LAT) tick();
    drive_a(0, 1, 1, 11'h123, 9'h000);
    repeat (LAT) tick();
    checks++;
    if (obs[0] !== 9'h1A5) begin
      fails++;
      $display("FAIL ssr_disabled_hold: got %h expected %h", obs[0], 9'h1A5);
    end
    drive_a(1, 0, 1, 11'h123, 9'h000);
    repeat (LAT) tick();
    checks++;
    if (obs[0] !== 9'h1FF) begin
      fails++;
      $display("FAIL ssr_srval_a: got %h expected %h", obs[0], 9'h1FF);
    end
    checks++;
    if (obs[2] !== 9'h123) begin
      fails++;
      $display("FAIL ssr_srval_a_dut1: got %h expected %h", obs[2], 9'h123);
    end
    drive_a(1, 1, 1, 11'h030, 9'h0D2);
    tick();
    drive_a(1, 0, 0, 11'h123, 9'h000);
    repeat (LAT) tick();
    checks++;
    if (obs[0] !== 9'h1A5) begin
      fails++;
      $display("FAIL disabled_write_ignored: got %h expected %h", obs[0], 9'h1A5);
    end
    drive_a(1, 0, 0, 11'h030, 9'h000);
    repeat (LAT) tick();
    checks++;
    if (obs[0] !== 9'h0D2) begin
      fails++;
      $display("FAIL ssr_write_still: got %h expected %h", obs[0], 9'h0D2);
    end
    drive_a(0, 0, 0, 11'h000, 9'h000);
  endtask

  task automatic test_async_reset();
    drive_a(1, 0, 0, 11'h123, 9'h000);
    drive_b(1, 0, 0, 11'h7FF, 9'h000);
    repeat (LAT) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (obs[p] !== ini[p]) begin
        fails++;
        $display("FAIL async_reset port%0d: got %h expected %h", p, obs[p], ini[p]);
      end
    end
    @(negedge clk);
    drive_a(1, 1, 0, 11'h123, 9'h000);
    drive_b(1, 1, 0, 11'h7FF, 9'h000);
    tick();
    rst = 1'b0;
    drive_a(0, 0, 0, 11'h000, 9'h000);
    drive_b(0, 0, 0, 11'h000, 9'h000);
    tick();
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (obs[p] !== ini[p]) begin
        fails++;
        $display("FAIL reset_release_hold port%0d: got %h expected %h", p, obs[p], ini[p]);
      end
    end
    drive_a(1, 0, 0, 11'h123, 9'h000);
    drive_b(1, 0, 0, 11'h7FF, 9'h000);
    repeat (LAT) tick();
    checks++;
    if (obs[0] !== 9'h1A5) begin
      fails++;
      $display("FAIL reset_no_write_a: got %h expected %h", obs[0], 9'h1A5);
    end
    checks++;
    if (obs[1] !== 9'h03C) begin
      fails++;
      $display("FAIL reset_no_write_b: got %h expected %h", obs[1], 9'h03C);
    end
    drive_a(0, 0, 0, 11'h000, 9'h000);
    drive_b(0, 0, 0, 11'h000, 9'h000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      drive_a(1, 1, 0, 11'(i), 9'($urandom));
      tick();
    end
    for (int i = 0; i < 400; i++) begin
      drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
              11'($urandom_range(0, 15)), 9'($urandom));
      drive_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
              11'($urandom_range(0, 15)), 9'($urandom));
      tick();
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs[p] !== exp_o(p)) begin
          fails++;
          $display("FAIL random cycle%0d port%0d: got %h expected %h", i, p, obs[p], exp_o(p));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read_a();
    test_cross_port();
    test_write_modes();
    test_collision();
    test_ssr_enable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
